window_pool_engine: RTL

Streaming, parametrised KxK pooling engine, the next generation of the fixed 3x3 combinational mean-absolute-deviation pooling kernel. Accepts one window row (K pixels) per handshake and accumulates K rows. Emits one pooled pixel per window in one of three runtime modes: mean horizontal absolute deviation, average, or max. Sits between the BRAM window fetcher and the pooled-result writeback, with valid/ready on both sides.

---
 rtl/pool_pkg.sv | 30 +++
 rtl/seq_divider.sv | 61 ++++++
 rtl/window_pool_engine.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pool_pkg.sv
// Shared types and helpers for the window pooling engine: mode/state encodings and divisor lookup.
package pool_pkg;

  typedef enum logic [1:0] {
    MODE_MAD = 2'd0,
    MODE_AVG = 2'd1,
    MODE_MAX = 2'd2
  } pool_mode_e;

  typedef enum logic [1:0] {
    StAccum  = 2'd0,
    StDivide = 2'd1,
    StOut    = 2'd2
  } pool_state_e;

  // Encoding 3 is an alias of AVG.
  function automatic pool_mode_e norm_mode(input logic [1:0] m);
    case (m)
      2'd0:    return MODE_MAD;
      2'd2:    return MODE_MAX;
      default: return MODE_AVG;
    endcase
  endfunction

  function automatic int unsigned div_for(input pool_mode_e m, input int unsigned k);
    if (m == MODE_MAD) return k * (k - 1);
    return k * k;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; the first bit is resolved on the start
// edge so done pulses W-1 cycles after start and the quotient is valid from then on.
module seq_divider #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, quo_q;
  logic [W-1:0]  rem_in, quo_in, rem_out, quo_out;
  logic [W:0]    shifted;
  logic [CW-1:0] cnt_q;
  logic          done_q;

  always_comb begin
    rem_in  = start ? '0 : rem_q;
    quo_in  = start ? dividend : quo_q;
    shifted = {rem_in, quo_in[W-1]};
    rem_out = rem_in;
    quo_out = {quo_in[W-2:0], 1'b0};
    if (shifted >= {1'b0, divisor}) begin
      rem_out    = W'(shifted - {1'b0, divisor});
      quo_out[0] = 1'b1;
    end else begin
      rem_out = shifted[W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q <= rem_out;
        quo_q <= quo_out;
        cnt_q <= CW'(W - 1);
      end else if (cnt_q != '0) begin
        rem_q  <= rem_out;
        quo_q  <= quo_out;
        cnt_q  <= cnt_q - 1'b1;
        done_q <= (cnt_q == CW'(1));
      end
    end
  end

  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/window_pool_engine.sv
// Streaming KxK pooling engine (MAD / AVG / MAX), one window row per beat.
// Define POOL_ROUND_EN to round the MAD/AVG quotient half up instead of truncating.
module window_pool_engine
  import pool_pkg::*;
#(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned K      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [K*DWIDTH-1:0]   in_row,
  input  logic [1:0]            mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DWIDTH-1:0]     out_data,
  output logic                  busy
);

  localparam int unsigned ACCW = DWIDTH + $clog2(K * K);
`ifdef POOL_ROUND_EN
  localparam int unsigned DIVW = ACCW + 1;
`else
  localparam int unsigned DIVW = ACCW;
`endif
  localparam int unsigned RCW = $clog2(K);

  pool_state_e       state_q, state_d;
  logic [RCW-1:0]    row_cnt_q, row_cnt_d;
  logic [ACCW-1:0]   acc_q, acc_d;
  pool_mode_e        mode_q, mode_d, eff_mode;
  logic [DWIDTH-1:0] out_data_q, out_data_d;

  logic [ACCW-1:0]   contrib_mad, contrib_sum, contrib;
  logic [DWIDTH-1:0] contrib_max, pa, pb;
  logic              row_hs, div_start, div_done;
  logic [DIVW-1:0]   div_dividend, div_divisor, div_quotient;
  logic              unused_quotient;

  always_comb begin
    contrib_mad = '0;
    contrib_sum = '0;
    contrib_max = '0;
    pa          = '0;
    pb          = '0;
    for (int c = 0; c < K; c++) begin
      pa          = in_row[c*DWIDTH +: DWIDTH];
      contrib_sum = contrib_sum + ACCW'(pa);
      if (pa > contrib_max) contrib_max = pa;
    end
    for (int c = 0; c < K - 1; c++) begin
      pa          = in_row[c*DWIDTH +: DWIDTH];
      pb          = in_row[(c+1)*DWIDTH +: DWIDTH];
      contrib_mad = contrib_mad + ACCW'((pa > pb) ? (pa - pb) : (pb - pa));
    end
  end

  // Mode is taken live on row 0 and frozen in mode_q for the rest of the window.
  assign eff_mode = (row_cnt_q == '0) ? norm_mode(mode) : mode_q;
  assign in_ready = (state_q == StAccum);
  assign row_hs   = in_valid & in_ready;

  always_comb begin
    unique case (eff_mode)
      MODE_MAD: contrib = contrib_mad;
      MODE_MAX: contrib = ACCW'(contrib_max);
      default:  contrib = contrib_sum;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    acc_d      = acc_q;
    mode_d     = mode_q;
    out_data_d = out_data_q;
    div_start  = 1'b0;
    unique case (state_q)
      StAccum: begin
        if (row_hs) begin
          mode_d = eff_mode;
          if (row_cnt_q == '0) begin
            acc_d = contrib;
          end else if (eff_mode == MODE_MAX) begin
            acc_d = (contrib > acc_q) ? contrib : acc_q;
          end else begin
            acc_d = acc_q + contrib;
          end
          if (row_cnt_q == RCW'(K - 1)) begin
            row_cnt_d = '0;
            if (eff_mode == MODE_MAX) begin
              state_d    = StOut;
              out_data_d = acc_d[DWIDTH-1:0];
            end else begin
              state_d   = StDivide;
              div_start = 1'b1;
            end
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      StDivide: begin
        if (div_done) begin
          state_d    = StOut;
          out_data_d = div_quotient[DWIDTH-1:0];
        end
      end
      StOut: begin
        if (out_ready) state_d = StAccum;
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StAccum;
      row_cnt_q  <= '0;
      acc_q      <= '0;
      mode_q     <= MODE_MAD;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      acc_q      <= acc_d;
      mode_q     <= mode_d;
      out_data_q <= out_data_d;
    end
  end

  // The last row is never row 0 (K >= 2), so mode_q already holds the window mode here.
  assign div_divisor = DIVW'(div_for(mode_q, K));
`ifdef POOL_ROUND_EN
  assign div_dividend = DIVW'(acc_d) + DIVW'(div_for(mode_q, K) / 2);
`else
  assign div_dividend = acc_d;
`endif

  seq_divider #(
    .W(DIVW)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .done     (div_done),
    .quotient (div_quotient)
  );

  assign unused_quotient = ^div_quotient[DIVW-1:DWIDTH];

  assign out_valid = (state_q == StOut);
  assign out_data  = out_data_q;
  assign busy      = (row_cnt_q != '0) || (state_q != StAccum);

endmodule
